// File: rtl/divider_16b_by_8b_if.sv
// rtl/divider_16b_by_8b_if.sv - request/result bundle for the 16/8 restoring divider
interface divider_16b_by_8b_if;
  logic        start;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic [7:0]  quotient;
  logic [7:0]  remainder;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic        overflow;

  modport master (
    output start, dividend, divisor,
    input  quotient, remainder, busy, done, div_zero, overflow
  );

  modport slave (
    input  start, dividend, divisor,
    output quotient, remainder, busy, done, div_zero, overflow
  );
endinterface

// File: rtl/divider_16b_by_8b.sv
// rtl/divider_16b_by_8b.sv - sequential unsigned 16/8 restoring divider, one quotient bit per clock
module divider_16b_by_8b (
  input  logic                 clk_i,
  input  logic                 rst_i,
  divider_16b_by_8b_if.slave   bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0] state_q, state_d;
  logic [7:0] r_q, r_d;
  logic [7:0] q_q, q_d;
  logic [7:0] d_q, d_d;
  logic [2:0] cnt_q, cnt_d;
  logic       pend_dz_q, pend_dz_d;
  logic       pend_ov_q, pend_ov_d;
  logic [7:0] quotient_q, quotient_d;
  logic [7:0] remainder_q, remainder_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       div_zero_q, div_zero_d;
  logic       overflow_q, overflow_d;

  logic [8:0] t;
  logic       t_ge_d;
  logic [7:0] r_step;
  logic [7:0] q_step;

  // T < 2*D always, so T - D fits in 8 bits even though the compare needs 9.
  assign t      = {r_q, q_q[7]};
  assign t_ge_d = (t >= {1'b0, d_q});
  assign r_step = t_ge_d ? (t[7:0] - d_q) : t[7:0];
  assign q_step = {q_q[6:0], t_ge_d};

  always_comb begin
    state_d     = state_q;
    r_d         = r_q;
    q_d         = q_q;
    d_d         = d_q;
    cnt_d       = cnt_q;
    pend_dz_d   = pend_dz_q;
    pend_ov_d   = pend_ov_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    div_zero_d  = div_zero_q;
    overflow_d  = overflow_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          busy_d    = 1'b1;
          state_d   = CALC;
          cnt_d     = 3'd0;
          pend_dz_d = 1'b0;
          pend_ov_d = 1'b0;
          if (bus.divisor == 8'd0) begin
            pend_dz_d = 1'b1;
          end else if (bus.dividend[15:8] >= bus.divisor) begin
            pend_ov_d = 1'b1;
          end else begin
            r_d = bus.dividend[15:8];
            q_d = bus.dividend[7:0];
            d_d = bus.divisor;
          end
        end
      end
      CALC: begin
        // A rejected request spends one cycle here so its result appears at k+1.
        if (pend_dz_q || pend_ov_q) begin
          quotient_d  = 8'hFF;
          remainder_d = 8'h00;
          div_zero_d  = pend_dz_q;
          overflow_d  = pend_ov_q;
          done_d      = 1'b1;
          state_d     = DONE;
        end else begin
          r_d   = r_step;
          q_d   = q_step;
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            quotient_d  = q_step;
            remainder_d = r_step;
            div_zero_d  = 1'b0;
            overflow_d  = 1'b0;
            done_d      = 1'b1;
            state_d     = DONE;
          end
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      r_q         <= 8'd0;
      q_q         <= 8'd0;
      d_q         <= 8'd0;
      cnt_q       <= 3'd0;
      pend_dz_q   <= 1'b0;
      pend_ov_q   <= 1'b0;
      quotient_q  <= 8'd0;
      remainder_q <= 8'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      div_zero_q  <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      r_q         <= r_d;
      q_q         <= q_d;
      d_q         <= d_d;
      cnt_q       <= cnt_d;
      pend_dz_q   <= pend_dz_d;
      pend_ov_q   <= pend_ov_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      div_zero_q  <= div_zero_d;
      overflow_q  <= overflow_d;
    end
  end

  assign bus.quotient  = quotient_q;
  assign bus.remainder = remainder_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.div_zero  = div_zero_q;
  assign bus.overflow  = overflow_q;

endmodule
